// File: rtl/cla_seq_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : cla_seq_adder_if
// Description : Operand/result handshake bundle for the sequential CLA adder.
// Revision    : 1.0 - initial release
// ============================================================================
interface cla_seq_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             is_not_equal;
    logic             is_less_than;

    // Producer of operands / consumer of results
    modport master (
        output in_valid,
        output op_a,
        output op_b,
        output op_sub,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  carry_out,
        input  overflow,
        input  is_not_equal,
        input  is_less_than
    );

    // The adder itself
    modport slave (
        input  in_valid,
        input  op_a,
        input  op_b,
        input  op_sub,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output carry_out,
        output overflow,
        output is_not_equal,
        output is_less_than
    );
endinterface
`default_nettype wire

// File: rtl/cla_seq_adder.sv
`default_nettype none
// ============================================================================
// Module      : cla_seq_adder (with helper cla_8)
// Description : WIDTH-bit add/sub that time-shares one 8-bit carry-lookahead
//               slice over WIDTH/8 cycles, LSB slice first. Optional compare
//               flags are enabled by defining CLA_SEQ_CMP_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// cla_8 : 8-bit carry-lookahead adder slice with signed-overflow output.
// ----------------------------------------------------------------------------
module cla_8 (
    input  wire logic [7:0] i_a,
    input  wire logic [7:0] i_b,
    input  wire logic       i_cin,
    output logic      [7:0] o_sum,
    output logic            o_cout,
    output logic            o_signed_ovf
);
    logic [7:0] w_g;
    logic [7:0] w_p;
    logic [8:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Carry into bit n as a flat sum of products: no carry ripples through
    // lower bit positions.
    function automatic logic f_lookahead(
        input logic [7:0] g,
        input logic [7:0] p,
        input logic       cin,
        input int         n
    );
        logic carry;
        logic term;
        carry = 1'b0;
        for (int j = 0; j <= 8; j++) begin
            if (j <= n) begin
                term = (j == 0) ? cin : g[j-1];
                for (int k = 0; k < 8; k++) begin
                    if (k >= j && k < n) begin
                        term = term & p[k];
                    end
                end
                carry = carry | term;
            end
        end
        return carry;
    endfunction

    for (genvar i = 0; i <= 8; i++) begin : g_carry
        assign w_c[i] = f_lookahead(w_g, w_p, i_cin, i);
    end

    assign o_sum        = w_p ^ w_c[7:0];
    assign o_cout       = w_c[8];
    assign o_signed_ovf = w_c[8] ^ w_c[7];
endmodule

// ----------------------------------------------------------------------------
// cla_seq_adder : sequencer around a single shared cla_8.
// ----------------------------------------------------------------------------
module cla_seq_adder #(
    parameter int WIDTH = 32
) (
    input  wire logic     clock,
    input  wire logic     reset_n,
    cla_seq_adder_if.slave bus
);
    localparam int c_NSLICES = WIDTH / 8;
    localparam int c_IDX_W   = (c_NSLICES > 1) ? $clog2(c_NSLICES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [c_IDX_W-1:0] r_idx;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry_out;
    logic               r_overflow;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;
    logic               w_run;
    logic               w_last;
    logic [7:0]         w_a_slice;
    logic [7:0]         w_b_slice;
    logic [7:0]         w_sum;
    logic               w_cout;
    logic               w_ovf;

    assign w_accept  = (r_state == S_IDLE) && bus.in_valid;
    assign w_run     = (r_state == S_RUN);
    assign w_last    = (r_idx == c_IDX_W'(c_NSLICES - 1));
    assign w_a_slice = r_a[8*r_idx +: 8];
    assign w_b_slice = r_b[8*r_idx +: 8];

    cla_8 u_cla_8 (
        .i_a          (w_a_slice),
        .i_b          (w_b_slice),
        .i_cin        (r_carry),
        .o_sum        (w_sum),
        .o_cout       (w_cout),
        .o_signed_ovf (w_ovf)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // B is pre-inverted for subtraction; the +1 enters as the slice-0 carry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a     <= bus.op_a;
                r_b     <= bus.op_b ^ {WIDTH{bus.op_sub}};
                r_carry <= bus.op_sub;
                r_idx   <= '0;
            end
            if (w_run) begin
                r_result[8*r_idx +: 8] <= w_sum;
                r_carry                <= w_cout;
                r_idx                  <= w_last ? '0 : r_idx + c_IDX_W'(1);
                if (w_last) begin
                    r_carry_out <= w_cout;
                    r_overflow  <= w_ovf;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_result;
    assign bus.carry_out = r_carry_out;
    assign bus.overflow  = r_overflow;

`ifdef CLA_SEQ_CMP_FLAGS_EN
    logic             r_sub;
    logic             r_ne;
    logic             r_lt;
    logic [WIDTH-1:0] w_final;

    // Full result as it will look once the top slice lands this cycle.
    always_comb begin
        w_final                  = r_result;
        w_final[WIDTH-8 +: 8]    = w_sum;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sub <= 1'b0;
            r_ne  <= 1'b0;
            r_lt  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sub <= bus.op_sub;
            end
            if (w_run && w_last) begin
                r_ne <= r_sub & (w_final != '0);
                r_lt <= r_sub & (w_sum[7] ^ w_ovf);
            end
        end
    end

    assign bus.is_not_equal = r_ne;
    assign bus.is_less_than = r_lt;
`else
    assign bus.is_not_equal = 1'b0;
    assign bus.is_less_than = 1'b0;
`endif

endmodule
`default_nettype wire
